countdown_sampler: RTL

//   Consumer-side counterpart of the bounded up-counter: accepts a bound n over a valid/ready

---
 rtl/countdown_pkg.sv | 17 +
 rtl/countdown_core.sv | 39 +++
 rtl/countdown_sampler.sv | 117 +++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg
//   Shared types and defaults for the countdown sampler.
//   cd_state_t     : controller state encoding (2 bits)
//   CD_WIDTH_DEF   : default datapath width
//   CD_RESET_N_DEF : default bound held in n after reset
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cd_state_t;

  localparam int CD_WIDTH_DEF   = 19;
  localparam int CD_RESET_N_DEF = 200;

endpackage

// File: rtl/countdown_core.sv
// countdown_core
//   Remaining-count register for the countdown sampler.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_val into x (takes priority over dec)
//   load_val   : value loaded into x
//   dec        : decrement x by one
//   x          : remaining count
//   last       : x == 1, i.e. the next decrement empties the counter
module countdown_core
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] x,
  output logic             last
);

  logic zero;

  assign zero = (x == '0);
  assign last = (x == WIDTH'(1));

  // Decrement is blocked at zero so the count can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
    end else if (load) begin
      x <= load_val;
    end else if (dec && !zero) begin
      x <= x - WIDTH'(1);
    end
  end

endmodule

// File: rtl/countdown_sampler.sv
// countdown_sampler
//   Accepts a bound over a valid/ready load port, drains x from the bound
//   down to 0 and optionally samples x into m on each drain step.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld_valid   : load request
//   ld_n       : bound to load
//   ld_ready   : high only in IDLE
//   en         : drain enable; everything holds in RUN when low
//   selector   : on a drain step, m takes the pre-decrement x
//   n          : latched bound
//   x          : remaining count
//   m          : last sampled x
//   done       : one-cycle pulse when the drain completes
//   Optional macro COUNTDOWN_ASSERT_EN embeds invariant assertions.
//
//   state | meaning
//   IDLE  | waiting for a load, ld_ready high
//   RUN   | draining x while en is high
//   DONE  | drain finished, done high for this cycle only
module countdown_sampler
  import countdown_pkg::*;
#(
  parameter int WIDTH   = CD_WIDTH_DEF,
  parameter int RESET_N = CD_RESET_N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_n,
  output logic             ld_ready,
  input  logic             en,
  input  logic             selector,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] m,
  output logic             done
);

  localparam logic [WIDTH-1:0] N_RST = WIDTH'(RESET_N);

  cd_state_t state;
  logic      load;
  logic      dec;
  logic      last;

  // ld_ready is registered and mirrors state==IDLE, so it doubles as the accept qualifier.
  assign load = ld_valid && ld_ready;
  assign dec  = (state == RUN) && en;

  countdown_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (ld_n),
    .dec      (dec),
    .x        (x),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n        <= N_RST;
      m        <= '0;
      done     <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            n        <= ld_n;
            m        <= '0;
            ld_ready <= 1'b0;
            // A zero bound has nothing to drain and completes immediately.
            if (ld_n != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            if (selector) m <= x;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          ld_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          ld_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef COUNTDOWN_ASSERT_EN
  a_m_bounded: assert property (@(posedge clk) disable iff (!rst_n) (x != '0) || (m <= n));
  a_x_bounded: assert property (@(posedge clk) disable iff (!rst_n) x <= n);
  a_done_zero: assert property (@(posedge clk) disable iff (!rst_n) done |-> (x == '0));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n) ld_ready == (state == IDLE));
`else
  // Invariant checkers are compiled out in this build.
`endif

endmodule
